// File: rtl/huffman_decoder.sv
// Serial canonical-Huffman decoder: 8 symbols, MSB-first bits in, one symbol out per codeword.
// Optional `HUFF_FLUSH_EN adds a synchronous flush input and a flushed_len report output.
module huffman_decoder #(
   parameter int unsigned MAX_LEN = 5,
   parameter int unsigned SYM_W   = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic [SYM_W-1:0] out_sym,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] sym_count
`ifdef HUFF_FLUSH_EN
   ,
   input  logic             flush,
   output logic [2:0]       flushed_len
`endif
);

   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t state, state_n;

   // A prefix is at most MAX_LEN-1 bits long, so the top accumulator bit is never stored.
   logic [MAX_LEN-2:0] code, code_n;
   logic [LEN_W-1:0]   len, len_n, cand_len;
   logic [MAX_LEN-1:0] cand, first, offset;
   logic [SYM_W-1:0]   base, sym_n;
   logic [2:0]         count;
   logic               accept, hit, done, flush_now;

`ifdef HUFF_FLUSH_EN
   assign flush_now = flush;
`else
   assign flush_now = 1'b0;
`endif

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign busy     = (state == S_ACCUM);
   assign cand     = {code, in_bit};
   assign cand_len = len + 1'b1;

   // Canonical table: first code, number of codes and base symbol for each length.
   always_comb begin
      first = '0;
      count = '0;
      base  = '0;
      case (cand_len)
         LEN_W'(2): begin first = MAX_LEN'(5'b00000); count = 3'd2; base = SYM_W'(0); end
         LEN_W'(3): begin first = MAX_LEN'(5'b00100); count = 3'd3; base = SYM_W'(2); end
         LEN_W'(4): begin first = MAX_LEN'(5'b01110); count = 3'd1; base = SYM_W'(5); end
         LEN_W'(5): begin first = MAX_LEN'(5'b11110); count = 3'd2; base = SYM_W'(6); end
         default:   begin first = '0;                 count = 3'd0; base = '0;        end
      endcase
   end

   assign offset = cand - first;
   assign hit    = (count != 3'd0) && (offset < MAX_LEN'(count));
   assign sym_n  = base + SYM_W'(offset);

   always_comb begin
      state_n = state;
      code_n  = code;
      len_n   = len;
      done    = 1'b0;
      if (flush_now) begin
         state_n = S_IDLE;
         code_n  = '0;
         len_n   = '0;
      end else if (accept) begin
         if (hit) begin
            done    = 1'b1;
            state_n = S_IDLE;
            code_n  = '0;
            len_n   = '0;
         end else begin
            state_n = S_ACCUM;
            code_n  = cand[MAX_LEN-2:0];
            len_n   = cand_len;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         code  <= '0;
         len   <= '0;
      end else begin
         state <= state_n;
         code  <= code_n;
         len   <= len_n;
      end
   end

   // A completing symbol takes priority over clearing, so a consumed slot can be refilled at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sym   <= '0;
         sym_count <= '0;
      end else begin
         if (done) begin
            out_valid <= 1'b1;
            out_sym   <= sym_n;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready)
            sym_count <= sym_count + 1'b1;
      end
   end

`ifdef HUFF_FLUSH_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         flushed_len <= '0;
      else if (flush)
         flushed_len <= 3'(len);
   end
`endif

   a_len_below_max: assert property (@(posedge clk) disable iff (reset) len < LEN_W'(MAX_LEN));

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder; a second instance with a narrow counter checks wrap.
module tb_huffman_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready, out_valid, busy;
   logic [3:0] out_sym;
   logic [15:0] sym_count;
   logic       w_in_ready, w_out_valid, w_busy;
   logic [3:0] w_out_sym;
   logic [3:0] w_count;
`ifdef HUFF_FLUSH_EN
   logic       flush = 1'b0;
   logic [2:0] flushed_len, w_flushed_len;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   huffman_decoder #(.MAX_LEN(5), .SYM_W(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_sym(out_sym), .out_ready(out_ready), .busy(busy),
      .sym_count(sym_count)
`ifdef HUFF_FLUSH_EN
      , .flush(flush), .flushed_len(flushed_len)
`endif
   );

   huffman_decoder #(.MAX_LEN(5), .SYM_W(4), .CNT_W(4)) u_wrap (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .in_ready(w_in_ready),
      .out_valid(w_out_valid), .out_sym(w_out_sym), .out_ready(out_ready), .busy(w_busy),
      .sym_count(w_count)
`ifdef HUFF_FLUSH_EN
      , .flush(flush), .flushed_len(w_flushed_len)
`endif
   );

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      in_valid = 1'b1;
      in_bit = b;
      @(posedge clk); #1;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
      checks++; if (out_sym !== 4'd0) begin errors++; $display("FAIL rst_sym got %0d exp 0", out_sym); end
      checks++; if (sym_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", sym_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
`ifdef HUFF_FLUSH_EN
      checks++; if (flushed_len !== 3'd0) begin errors++; $display("FAIL rst_flushed_len got %0d exp 0", flushed_len); end
`endif
   endtask

   task automatic test_full_table();
      logic [4:0] codes [8];
      int         lens  [8];
      logic [4:0] cw;
      codes = '{5'b00, 5'b01, 5'b100, 5'b101, 5'b110, 5'b1110, 5'b11110, 5'b11111};
      lens  = '{2, 2, 3, 3, 3, 4, 5, 5};
      do_reset();
      out_ready = 1'b1;
      for (int s = 0; s < 8; s++) begin
         cw = codes[s];
         for (int i = lens[s] - 1; i >= 0; i--) begin
            send_bit(cw[i]);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL tbl_in_ready sym %0d got %0b exp 1", s, in_ready); end
            if (i == 0) begin
               checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tbl_valid sym %0d got %0b exp 1", s, out_valid); end
               checks++; if (out_sym !== 4'(s)) begin errors++; $display("FAIL tbl_sym got %0d exp %0d", out_sym, s); end
            end else begin
               checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tbl_novalid sym %0d bit %0d got %0b exp 0", s, i, out_valid); end
            end
         end
      end
      idle_cycle();
      checks++; if (sym_count !== 16'd8) begin errors++; $display("FAIL tbl_count got %0d exp 8", sym_count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tbl_drain got %0b exp 0", out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b exp 1", out_valid); end
      checks++; if (out_sym !== 4'd2) begin errors++; $display("FAIL bp_sym got %0d exp 2", out_sym); end
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_bit = 1'b1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %0b exp 0", c, in_ready); end
         @(posedge clk); #1;
         checks++; if (out_sym !== 4'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got %0b/%0d exp 1/2", c, out_valid, out_sym); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy cyc %0d got %0b exp 0", c, busy); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b exp 0", out_valid); end
      checks++; if (sym_count !== 16'd1) begin errors++; $display("FAIL bp_count got %0d exp 1", sym_count); end
      send_bit(1'b0);
      send_bit(1'b1);
      checks++; if (out_valid !== 1'b1 || out_sym !== 4'd1) begin errors++; $display("FAIL bp_after got %0b/%0d exp 1/1", out_valid, out_sym); end
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      send_bit(1'b0);
      send_bit(1'b0);
      checks++; if (out_valid !== 1'b1 || out_sym !== 4'd0) begin errors++; $display("FAIL b2b_first got %0b/%0d exp 1/0", out_valid, out_sym); end
      out_ready = 1'b0;
      idle_cycle();
      checks++; if (sym_count !== 16'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold got %0d/%0b exp 0/1", sym_count, out_valid); end
      out_ready = 1'b1;
      send_bit(1'b0);
      checks++; if (out_valid !== 1'b0 || sym_count !== 16'd1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_mid got v%0b c%0d b%0b exp v0 c1 b1", out_valid, sym_count, busy); end
      send_bit(1'b1);
      checks++; if (out_valid !== 1'b1 || out_sym !== 4'd1) begin errors++; $display("FAIL b2b_second got %0b/%0d exp 1/1", out_valid, out_sym); end
      checks++; if (sym_count !== 16'd1) begin errors++; $display("FAIL b2b_count_once got %0d exp 1", sym_count); end
      idle_cycle();
      checks++; if (sym_count !== 16'd2) begin errors++; $display("FAIL b2b_count_end got %0d exp 2", sym_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      send_bit(1'b0);
      send_bit(1'b1);
      out_ready = 1'b1;
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1 || sym_count !== 16'd1) begin errors++; $display("FAIL mid_pre got b%0b c%0d exp b1 c1", busy, sym_count); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b exp 0", busy); end
      checks++; if (out_valid !== 1'b0 || out_sym !== 4'd0) begin errors++; $display("FAIL mid_out got %0b/%0d exp 0/0", out_valid, out_sym); end
      checks++; if (sym_count !== 16'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", sym_count); end
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %0b exp 1", in_ready); end
      send_bit(1'b0);
      send_bit(1'b0);
      checks++; if (out_valid !== 1'b1 || out_sym !== 4'd0) begin errors++; $display("FAIL mid_after got %0b/%0d exp 1/0", out_valid, out_sym); end
      idle_cycle();
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 1'b1;
      for (int n = 0; n < 16; n++) begin
         send_bit(1'b0);
         send_bit(1'b0);
      end
      idle_cycle();
      checks++; if (w_count !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", w_count); end
      checks++; if (sym_count !== 16'd16) begin errors++; $display("FAIL wrap_main got %0d exp 16", sym_count); end
      send_bit(1'b0);
      send_bit(1'b0);
      idle_cycle();
      checks++; if (w_count !== 4'd1) begin errors++; $display("FAIL wrap_one got %0d exp 1", w_count); end
   endtask

`ifdef HUFF_FLUSH_EN
   task automatic test_flush();
      do_reset();
      out_ready = 1'b1;
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fl_busy_pre got %0b exp 1", busy); end
      in_valid = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (flushed_len !== 3'd4) begin errors++; $display("FAIL fl_len got %0d exp 4", flushed_len); end
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_state got b%0b v%0b exp b0 v0", busy, out_valid); end
      send_bit(1'b0);
      send_bit(1'b1);
      checks++; if (out_valid !== 1'b1 || out_sym !== 4'd1) begin errors++; $display("FAIL fl_after got %0b/%0d exp 1/1", out_valid, out_sym); end
      send_bit(1'b1);
      in_bit = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (flushed_len !== 3'd1 || busy !== 1'b0) begin errors++; $display("FAIL fl_discard got l%0d b%0b exp l1 b0", flushed_len, busy); end
      checks++; if (out_sym !== 4'd1 || sym_count !== 16'd1) begin errors++; $display("FAIL fl_out_kept got s%0d c%0d exp s1 c1", out_sym, sym_count); end
      send_bit(1'b0);
      send_bit(1'b0);
      checks++; if (out_valid !== 1'b1 || out_sym !== 4'd0) begin errors++; $display("FAIL fl_after2 got %0b/%0d exp 1/0", out_valid, out_sym); end
      idle_cycle();
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_full_table();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
`ifdef HUFF_FLUSH_EN
      test_flush();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
